// File: rtl/ex_operand_stage.sv
// ex_operand_stage: forwards writeback results into decoded ALU instructions,
// builds the ALU operand set and buffers it in a two-entry skid buffer.
// id_ready comes from registered state only, so EXE back-pressure never
// reaches ID combinationally.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_is_imm,
  input  logic [4:0]      id_rs1_idx,
  input  logic [4:0]      id_rs2_idx,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [2:0]      ex_funct3,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rb,
  output logic [4:0]      ex_shamt,
  output logic            ex_cin,
  output logic            ex_arith,
  output logic [4:0]      ex_rd
);

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rb;
    logic [4:0]      shamt;
    logic            cin;
    logic            arith;
    logic [4:0]      rd;
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Source operand with writeback forwarding; x0 always reads as zero.
  function automatic logic [XLEN-1:0] fwd_src(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_data,
    input logic            fw_valid,
    input logic [4:0]      fw_rd,
    input logic [XLEN-1:0] fw_data
  );
    logic [XLEN-1:0] val;
    if (idx == 5'd0) begin
      val = '0;
    end else if (fw_valid && (fw_rd == idx)) begin
      val = fw_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // SUB is turned into rs1 + ~rs2 + 1 so the ALU only needs an adder.
  // ADDI ignores funct7b5 because that bit belongs to its immediate.
  function automatic op_t build_op(
    input logic [2:0]      funct3,
    input logic            funct7b5,
    input logic            is_imm,
    input logic [XLEN-1:0] rs1,
    input logic [XLEN-1:0] rs2,
    input logic [XLEN-1:0] imm,
    input logic [4:0]      rd
  );
    op_t             op;
    logic [XLEN-1:0] rb_raw;
    logic            is_sub;
    rb_raw    = is_imm ? imm : rs2;
    is_sub    = (funct3 == 3'b000) && funct7b5 && !is_imm;
    op.funct3 = funct3;
    op.rs1    = rs1;
    op.rb     = is_sub ? ~rs2 : rb_raw;
    op.shamt  = rb_raw[4:0];
    op.cin    = is_sub;
    op.arith  = (funct3 == 3'b101) ? funct7b5 : 1'b0;
    op.rd     = rd;
    return op;
  endfunction

  state_t state_q, state_d;
  op_t    main_q, main_d;
  op_t    skid_q, skid_d;
  op_t    new_op;
  logic   accept;

  assign id_ready = (state_q != FULL);
  assign ex_valid = (state_q != EMPTY);

  assign ex_funct3 = main_q.funct3;
  assign ex_rs1    = main_q.rs1;
  assign ex_rb     = main_q.rb;
  assign ex_shamt  = main_q.shamt;
  assign ex_cin    = main_q.cin;
  assign ex_arith  = main_q.arith;
  assign ex_rd     = main_q.rd;

  // Build the incoming operand set and compute buffer next-state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = id_valid && (state_q != FULL);
    new_op  = build_op(id_funct3, id_funct7b5, id_is_imm,
                       fwd_src(id_rs1_idx, id_rs1_data, wb_valid, wb_rd, wb_data),
                       fwd_src(id_rs2_idx, id_rs2_data, wb_valid, wb_rd, wb_data),
                       id_imm, id_rd);
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = new_op;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && ex_ready) begin
            main_d = new_op;
          end else if (accept) begin
            skid_d  = new_op;
            state_d = FULL;
          end else if (ex_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (ex_ready) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Buffer state and entry registers; reset clears outputs to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with a scoreboard of expected operand sets.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_is_imm;
  logic [4:0]  id_rs1_idx, id_rs2_idx;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rb;
  logic [4:0]  ex_shamt;
  logic        ex_cin, ex_arith;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [78:0] sb[$];
  logic [78:0] prev_obs;
  logic        stall_prev = 1'b0;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_is_imm(id_is_imm),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rb(ex_rb),
    .ex_shamt(ex_shamt), .ex_cin(ex_cin), .ex_arith(ex_arith), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (wb_valid && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // Expected operand set for the instruction currently presented by ID.
  function automatic logic [78:0] model();
    logic [31:0] a, b, opnd, rb;
    logic        sub;
    a    = src(id_rs1_idx, id_rs1_data);
    b    = src(id_rs2_idx, id_rs2_data);
    opnd = id_is_imm ? id_imm : b;
    sub  = (id_funct3 == 3'd0) && id_funct7b5 && !id_is_imm;
    rb   = sub ? (32'd0 - b - 32'd1) : opnd;
    return {id_funct3, a, rb, opnd[4:0], sub,
            (id_funct3 == 3'd5) ? id_funct7b5 : 1'b0, id_rd};
  endfunction

  function automatic logic [78:0] obs_now();
    return {ex_funct3, ex_rs1, ex_rb, ex_shamt, ex_cin, ex_arith, ex_rd};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [2:0] f3, input logic f7, input logic isimm,
                       input logic [4:0] i1, input logic [31:0] d1,
                       input logic [4:0] i2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] rd);
    id_valid = 1'b1; id_funct3 = f3; id_funct7b5 = f7; id_is_imm = isimm;
    id_rs1_idx = i1; id_rs1_data = d1; id_rs2_idx = i2; id_rs2_data = d2;
    id_imm = imm; id_rd = rd;
  endtask

  // One clock: sample at the falling edge, score handshakes, return after posedge.
  task automatic tick();
    logic        hs, acc;
    logic [78:0] o, e;
    @(negedge clk);
    hs = ex_valid && ex_ready;
    acc = id_valid && id_ready;
    o = obs_now();
    if (stall_prev) begin
      chk("stall_valid", {95'd0, ex_valid}, 96'd1);
      chk("stall_stable", {17'd0, o}, {17'd0, prev_obs});
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (hs) begin
        chk("sb_nonempty", {95'd0, (sb.size() > 0)}, 96'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ex_out", {17'd0, o}, {17'd0, e});
        end
      end
      if (acc) sb.push_back(model());
    end
    stall_prev = ex_valid && !ex_ready && !flush;
    prev_obs = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    id_valid = 1'b0; id_funct3 = '0; id_funct7b5 = 1'b0; id_is_imm = 1'b0;
    id_rs1_idx = '0; id_rs2_idx = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ex_valid", {95'd0, ex_valid}, 96'd0);
    chk("rst_id_ready", {95'd0, id_ready}, 96'd1);
    chk("rst_outputs", {17'd0, obs_now()}, 96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic operations at full throughput
    ex_ready = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3);
    tick();
    chk("add_valid", {95'd0, ex_valid}, 96'd1);
    chk("add_rs1", {64'd0, ex_rs1}, 96'd5);
    chk("add_rb", {64'd0, ex_rb}, 96'd7);
    chk("add_cin_shamt", {90'd0, ex_cin, ex_shamt}, {90'd0, 1'b0, 5'd7});
    drive(3'b000, 1'b1, 1'b0, 5'd1, 32'd10, 5'd2, 32'd3, 32'd0, 5'd4);
    tick();
    chk("sub_rb", {64'd0, ex_rb}, {64'd0, 32'hFFFFFFFC});
    chk("sub_cin", {95'd0, ex_cin}, 96'd1);
    chk("sub_result", {64'd0, ex_rs1 + ex_rb + {31'd0, ex_cin}}, 96'd7);
    drive(3'b001, 1'b0, 1'b1, 5'd5, 32'h11, 5'd0, 32'd0, 32'h403, 5'd5);
    tick();
    chk("slli_shamt", {91'd0, ex_shamt}, 96'd3);
    chk("slli_rb", {64'd0, ex_rb}, 96'h403);
    chk("slli_arith", {95'd0, ex_arith}, 96'd0);
    drive(3'b101, 1'b1, 1'b1, 5'd6, 32'h80000000, 5'd0, 32'd0, 32'h405, 5'd6);
    tick();
    chk("srai_arith", {95'd0, ex_arith}, 96'd1);
    chk("srai_cin", {95'd0, ex_cin}, 96'd0);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD;
    drive(3'b000, 1'b0, 1'b0, 5'd4, 32'd0, 5'd6, 32'd1, 32'd0, 5'd7);
    tick();
    chk("fwd_rs1", {64'd0, ex_rs1}, 96'hDEAD);
    wb_rd = 5'd0; wb_data = 32'hBEEF;
    drive(3'b000, 1'b0, 1'b0, 5'd0, 32'h1234, 5'd0, 32'h99, 32'd0, 5'd8);
    tick();
    chk("fwd_x0", {64'd0, ex_rs1}, 96'd0);
    wb_rd = 5'd9; wb_data = 32'h20;
    drive(3'b000, 1'b1, 1'b0, 5'd3, 32'h100, 5'd9, 32'd0, 32'd0, 5'd9);
    tick();
    chk("fwd_rs2_sub", {64'd0, ex_rb}, {64'd0, 32'hFFFFFFDF});
    wb_valid = 1'b0;
    drive(3'b000, 1'b1, 1'b1, 5'd3, 32'h100, 5'd0, 32'd0, 32'hFFFFFFFF, 5'd10);
    tick();
    chk("addi_no_sub", {63'd0, ex_cin, ex_rb}, {64'd0, 32'hFFFFFFFF});
    id_valid = 1'b0;
    tick();

    // Back-pressure: A main, B skid, C held
    ex_ready = 1'b0;
    drive(3'b100, 1'b0, 1'b0, 5'd1, 32'hA, 5'd2, 32'hA0, 32'd0, 5'd11);
    tick();
    drive(3'b110, 1'b0, 1'b1, 5'd1, 32'hB, 5'd0, 32'd0, 32'h7FF, 5'd12);
    tick();
    chk("full_id_ready", {95'd0, id_ready}, 96'd0);
    drive(3'b111, 1'b0, 1'b0, 5'd2, 32'hC, 5'd3, 32'hC0, 32'd0, 5'd13);
    tick();
    tick();
    chk("held_id_ready", {95'd0, id_ready}, 96'd0);
    chk("held_main_rd", {91'd0, ex_rd}, 96'd11);
    ex_ready = 1'b1;
    tick();
    chk("after_full_id_ready", {95'd0, id_ready}, 96'd1);
    chk("after_full_main_rd", {91'd0, ex_rd}, 96'd12);
    tick();
    id_valid = 1'b0;
    tick();
    tick();
    chk("drained_valid", {95'd0, ex_valid}, 96'd0);
    chk("drained_sb", {64'd0, sb.size()}, 96'd0);

    // Flush in FULL with a same-cycle accept attempt
    ex_ready = 1'b0;
    drive(3'b010, 1'b0, 1'b0, 5'd1, 32'h21, 5'd2, 32'h22, 32'd0, 5'd14);
    tick();
    drive(3'b011, 1'b0, 1'b0, 5'd1, 32'h31, 5'd2, 32'h32, 32'd0, 5'd15);
    tick();
    flush = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 5'd1, 32'h41, 5'd2, 32'h42, 32'd0, 5'd16);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_ex_valid", {95'd0, ex_valid}, 96'd0);
    chk("flush_id_ready", {95'd0, id_ready}, 96'd1);
    ex_ready = 1'b1;
    tick();
    tick();
    chk("flush_nothing_out", {95'd0, ex_valid}, 96'd0);

    // Asynchronous reset mid-stream
    ex_ready = 1'b0;
    drive(3'b100, 1'b0, 1'b0, 5'd7, 32'hFFFF, 5'd8, 32'h1, 32'd0, 5'd17);
    tick();
    id_valid = 1'b0;
    chk("pre_rst_valid", {95'd0, ex_valid}, 96'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", {95'd0, ex_valid}, 96'd0);
    chk("arst_id_ready", {95'd0, id_ready}, 96'd1);
    chk("arst_outputs", {17'd0, obs_now()}, 96'd0);
    sb.delete();
    stall_prev = 1'b0;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    tick();
    chk("post_rst_idle", {95'd0, ex_valid}, 96'd0);
    drive(3'b000, 1'b0, 1'b1, 5'd2, 32'h50, 5'd0, 32'd0, 32'h5, 5'd18);
    tick();
    id_valid = 1'b0;
    tick();
    chk("final_sb_empty", {64'd0, sb.size()}, 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
